case_1_mul_arbiter: RTL and testbench
=====================================

CASE_1_MUL_ARBITER -- requirements
Module: case_1_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one signed multiplier.
REQ-002 SHALL have parameter A_WIDTH, default 10: signed operand A width.
REQ-003 SHALL have parameter B_WIDTH, default 9: signed operand B width.
REQ-004 SHALL have parameter P_WIDTH, default 19: product width, equal to A_WIDTH+B_WIDTH.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports ap_clk and ap_rst_n.
REQ-006 SHALL have port ap_clk, input, 1: rising-edge clock.
REQ-007 SHALL have port ap_rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, NUM_REQ: per-requester operation request.
REQ-009 SHALL have port req_ready, output, NUM_REQ: one-hot grant; operands taken when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port req_a, input, NUM_REQ*A_WIDTH: packed operand A; slice i belongs to requester i.
REQ-011 SHALL have port req_b, input, NUM_REQ*B_WIDTH: packed operand B; slice i belongs to requester i.
REQ-012 SHALL have port resp_valid, output, 1: result available.
REQ-013 SHALL have port resp_ready, input, 1: consumer accepts result.
REQ-014 SHALL have port resp_data, output, P_WIDTH: signed product.
REQ-015 SHALL have port resp_id, output, clog2(NUM_REQ): index of the requester that owns resp_data.
REQ-016 SHALL have port grant_cnt, output, 16: count of accepted operations; wraps 65535 -> 0.

Function
REQ-017 SHALL contain exactly one signed multiplier, computing $signed(A)*$signed(B) sign-extended to P_WIDTH; overflow is impossible.
REQ-018 SHALL define can_issue = !resp_valid || resp_ready.
REQ-019 SHALL make req_ready combinational: at most one bit high, and only when can_issue is high and the corresponding req_valid is high.
REQ-020 SHALL arbitrate round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-021 SHALL update last_grant only on an accepted request.
REQ-022 SHALL register the product, id, and resp_valid=1 on the edge that follows acceptance; latency is exactly 1 cycle.
REQ-023 SHALL sustain 1 operation per cycle while resp_ready is held high.
REQ-024 SHALL hold resp_valid, resp_data and resp_id stable while resp_valid=1 and resp_ready=0; no grant is issued during that time.
REQ-025 SHALL, when the output is consumed with no new acceptance in the same cycle, clear resp_valid on the next edge.
REQ-026 SHALL, when the output is consumed and a new request is accepted in the same cycle, load the new result with resp_valid staying 1 (no bubble).
REQ-027 SHALL increment grant_cnt by 1 per accepted request.
REQ-028 SHALL assume req_valid never depends on req_ready; a requester that drops valid before being granted loses its slot without error.

Reset
REQ-029 SHALL asynchronously set resp_valid=0, resp_data=0, resp_id=0, grant_cnt=0 and last_grant=NUM_REQ-1 while ap_rst_n=0.
REQ-030 SHALL keep req_ready all-zero while in reset; an in-flight result is discarded by reset.
REQ-031 SHALL accept its first request on the first rising edge after ap_rst_n deasserts.

Verification
REQ-032 Single request: req0 with A=-512, B=-256, resp_ready=1 -> next cycle resp_valid=1, resp_data=131072, resp_id=0, grant_cnt=1.
REQ-033 All 4 requesters valid continuously, resp_ready=1 -> grants issued in order 0,1,2,3,0,... one per cycle; products correct (e.g. 511*255=130305, -1*255=-255).
REQ-034 Backpressure: resp_ready=0 for 5 cycles with requests pending -> req_ready=0 throughout; resp_data/resp_id held; when resp_ready returns to 1, that cycle both consumes and grants with no bubble.
REQ-035 Fairness after skip: only req2 and req0 valid, with last_grant=0 -> req2 is granted before req0.
REQ-036 Reset mid-operation: assert ap_rst_n=0 while resp_valid=1 -> resp_valid, resp_data and grant_cnt go to 0 immediately (asynchronously); after release, req0 is granted first.
REQ-037 Counter wrap: 65536 accepted operations -> grant_cnt reads 0.

Source files
------------

// File: rtl/case_1_mul_arbiter.sv
// case_1_mul_arbiter: round-robin arbiter in front of one shared signed
// multiplier. One operation can be accepted per cycle; the registered
// product appears one cycle after acceptance together with the id of
// the requester that issued it.
module case_1_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 9,
    parameter int P_WIDTH = 19
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [P_WIDTH-1:0]           resp_data,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [15:0]                  grant_cnt
);

    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]       last_grant;
    logic [ID_WIDTH-1:0]       grant_idx;
    logic                      grant_found;
    logic [A_WIDTH-1:0]        a_sel;
    logic [B_WIDTH-1:0]        b_sel;
    logic signed [P_WIDTH-1:0] a_ext;
    logic signed [P_WIDTH-1:0] b_ext;
    logic signed [P_WIDTH-1:0] product;
    logic                      can_issue;
    logic                      accept;

    // Round-robin pick: first look above last_grant, then wrap to the bottom,
    // which is the same as searching from (last_grant+1) mod NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(last_grant))) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
                a_sel       = req_a[i*A_WIDTH +: A_WIDTH];
                b_sel       = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i <= int'(last_grant))) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
                a_sel       = req_a[i*A_WIDTH +: A_WIDTH];
                b_sel       = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // The output register can take a new result if it is empty or being drained.
    assign can_issue = !resp_valid || resp_ready;

    // One-hot grant, suppressed while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (ap_rst_n && can_issue && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Single shared multiplier; both operands sign-extended to the full product width.
    assign a_ext   = P_WIDTH'($signed(a_sel));
    assign b_ext   = P_WIDTH'($signed(b_sel));
    assign product = a_ext * b_ext;

    // Result register, arbitration pointer and accepted-operation counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            grant_cnt  <= '0;
            last_grant <= LAST_INIT;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= product;
            resp_id    <= grant_idx;
            grant_cnt  <= grant_cnt + 16'd1;
            last_grant <= grant_idx;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_case_1_mul_arbiter.sv
// tb_case_1_mul_arbiter: directed and randomized checks of the shared
// multiplier arbiter against a transaction-level model kept in the bench.
module tb_case_1_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int A_WIDTH = 10;
    localparam int B_WIDTH = 9;
    localparam int P_WIDTH = 19;

    logic                       ap_clk = 1'b0;
    logic                       ap_rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [P_WIDTH-1:0]         resp_data;
    logic [1:0]                 resp_id;
    logic [15:0]                grant_cnt;

    int op_a [NUM_REQ];
    int op_b [NUM_REQ];
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: the output slot, the round-robin pointer and the counter.
    bit m_valid;
    int m_data;
    int m_id;
    int m_cnt;
    int m_lg;

    case_1_mul_arbiter #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .grant_cnt(grant_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 ap_clk = ~ap_clk;

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_id    = 0;
        m_cnt   = 0;
        m_lg    = NUM_REQ - 1;
    endfunction

    // Requester the model would grant now, or -1 if none.
    function automatic int model_pick();
        if (!ap_rst_n) return -1;
        if (m_valid && !resp_ready) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req_valid[(m_lg + k) % NUM_REQ]) return (m_lg + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void model_commit(input int g);
        if (!ap_rst_n) return;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = op_a[g] * op_b[g];
            m_id    = g;
            m_lg    = g;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int          g;
        logic [31:0] d;
        logic [3:0]  exp_ready;
        g = model_pick();
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        d = m_data;
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
        check_eq({tag, ".resp_valid"}, 32'(resp_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq({tag, ".resp_data"}, 32'(resp_data), 32'(d[P_WIDTH-1:0]));
            check_eq({tag, ".resp_id"}, 32'(resp_id), m_id);
        end
        check_eq({tag, ".grant_cnt"}, 32'(grant_cnt), m_cnt);
    endtask

    // One clock cycle: drive inputs just after an edge, check, then advance the model on the edge.
    task automatic applyStimulus(input logic [3:0] v, input logic rr, input bit do_check, input string tag);
        int g;
        req_valid  = v;
        resp_ready = rr;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*A_WIDTH +: A_WIDTH] = op_a[i][A_WIDTH-1:0];
            req_b[i*B_WIDTH +: B_WIDTH] = op_b[i][B_WIDTH-1:0];
        end
        #1;
        if (do_check) checkOutput(tag);
        g = model_pick();
        @(posedge ap_clk);
        model_commit(g);
        #1;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = int'($urandom_range(0, 1023)) - 512;
            op_b[i] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
        end
        model_reset();

        // Reset state, with every requester asking.
        @(posedge ap_clk);
        #1;
        checkOutput("reset");
        check_eq("reset.resp_data", 32'(resp_data), 32'd0);
        check_eq("reset.resp_id", 32'(resp_id), 32'd0);
        ap_rst_n = 1'b1;

        // Single request: -512 * -256 from requester 0.
        op_a[0] = -512;
        op_b[0] = -256;
        applyStimulus(4'b0001, 1'b1, 1'b1, "single");
        checkOutput("single_out");
        check_eq("single.data_const", 32'(resp_data), 32'd131072);
        check_eq("single.cnt_const", 32'(grant_cnt), 32'd1);

        // All requesters valid: round-robin, one per cycle, including extreme operands.
        op_a[0] = 511; op_b[0] = 255;
        op_a[1] = -1;  op_b[1] = 255;
        op_a[2] = -512; op_b[2] = 255;
        op_a[3] = 511; op_b[3] = -256;
        for (int c = 0; c < 4; c++) applyStimulus(4'hF, 1'b1, 1'b1, "rr_dir");
        for (int c = 0; c < 8; c++) begin
            randomize_operands();
            applyStimulus(4'hF, 1'b1, 1'b1, "rr_rand");
        end

        // Backpressure for five cycles, then release with simultaneous consume and grant.
        for (int c = 0; c < 5; c++) applyStimulus(4'hF, 1'b0, 1'b1, "bp_hold");
        applyStimulus(4'hF, 1'b1, 1'b1, "bp_release");
        checkOutput("bp_after");

        // Fairness: after requester 0 wins, requester 2 goes before requester 0.
        applyStimulus(4'b0001, 1'b1, 1'b1, "fair_0");
        applyStimulus(4'b0101, 1'b1, 1'b1, "fair_2");
        check_eq("fair.id2", 32'(resp_id), 32'd2);
        applyStimulus(4'b0101, 1'b1, 1'b1, "fair_0b");
        check_eq("fair.id0", 32'(resp_id), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, "drain");

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            randomize_operands();
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b1, "random");
        end

        // Reset while a result is held: outputs clear immediately.
        applyStimulus(4'hF, 1'b0, 1'b1, "pre_reset");
        ap_rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("async_reset");
        check_eq("async_reset.resp_data", 32'(resp_data), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        randomize_operands();
        applyStimulus(4'hF, 1'b1, 1'b1, "post_reset");
        check_eq("post_reset.id0", 32'(resp_id), 32'd0);

        // Counter wrap: 65536 accepted operations bring grant_cnt back to 0.
        ap_rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        for (int c = 0; c < 65535; c++) applyStimulus(4'hF, 1'b1, 1'b0, "wrap_run");
        applyStimulus(4'hF, 1'b1, 1'b1, "wrap_last");
        checkOutput("wrap_done");
        check_eq("wrap.cnt_zero", 32'(grant_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
